// File: rtl/spike_rle_encoder_if.sv
// spike_rle_encoder_if: event stream handshake between the RLE encoder and its consumer.
//   ev_data  : FIFO head, bit GAP_W = type (1 spike / 0 idle marker), low bits = gap
//   ev_valid : head is valid (FIFO non-empty)
//   ev_ready : consumer accepts the head this cycle
// master = encoder side, slave = consumer side.
interface spike_rle_encoder_if #(
    parameter int unsigned GAP_W = 7
);
    localparam int unsigned EV_W = GAP_W + 1;

    logic [EV_W-1:0] ev_data;
    logic            ev_valid;
    logic            ev_ready;

    modport master (output ev_data, output ev_valid, input ev_ready);
    modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface

// File: rtl/spike_rle_encoder.sv
// spike_rle_encoder: run-length encodes a 1-bit spike train into (GAP_W+1)-bit events
// (spike + idle gap, or idle marker after 2^GAP_W silent cycles) and queues them in a
// small register FIFO drained over a valid/ready handshake.
// Ports:
//   clk, rst       : clock (rising edge), synchronous active-high reset
//   en, spike      : sample enable and spike input from the neuron stage
//   ev (master)    : ev_data / ev_valid / ev_ready event stream
//   fill           : current FIFO occupancy
//   ovf            : sticky flag, set when an event is dropped on a full FIFO
//   drop_cnt       : saturating count of dropped events
// Optional feature: define SPIKE_RLE_DROP_CNT_EN to build the drop counter;
// otherwise drop_cnt is tied to 0.
module spike_rle_encoder #(
    parameter int unsigned GAP_W = 7,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     spike,
    spike_rle_encoder_if.master      ev,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     ovf,
    output logic [7:0]               drop_cnt
);
    localparam int unsigned EV_W  = GAP_W + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [GAP_W-1:0] GAP_MAX = '1;

    logic [GAP_W-1:0] gap_q;
    logic [EV_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             valid_q;
    logic             ovf_q;

    logic             push_c;
    logic             pop_c;
    logic             accept_c;
    logic             reject_c;
    logic [EV_W-1:0]  push_data_c;
    logic [CNT_W-1:0] count_nxt_c;

    // Event generation: a spike, or a saturated gap, produces one event
    assign push_c      = en && (spike || (gap_q == GAP_MAX));
    assign push_data_c = spike ? {1'b1, gap_q} : {1'b0, GAP_MAX};

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign pop_c    = valid_q && ev.ev_ready;
    assign accept_c = push_c && ((count_q < CNT_W'(DEPTH)) || pop_c);
    assign reject_c = push_c && !accept_c;

    // Next occupancy
    always_comb begin
        count_nxt_c = count_q;
        unique case ({accept_c, pop_c})
            2'b10:   count_nxt_c = count_q + CNT_W'(1);
            2'b01:   count_nxt_c = count_q - CNT_W'(1);
            default: count_nxt_c = count_q;
        endcase
    end

    // Gap counter, FIFO storage/pointers and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            mem_q    <= '{default: '0};
        end else begin
            // gap restarts on every event, even a dropped one, to keep the stream aligned
            if (en) begin
                gap_q <= push_c ? '0 : gap_q + GAP_W'(1);
            end
            if (accept_c) begin
                mem_q[wr_ptr_q] <= push_data_c;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_nxt_c;
            valid_q <= (count_nxt_c != '0);
            if (reject_c) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign ev.ev_data  = mem_q[rd_ptr_q];
    assign ev.ev_valid = valid_q;
    assign fill        = count_q;
    assign ovf         = ovf_q;

`ifdef SPIKE_RLE_DROP_CNT_EN
    logic [7:0] drop_q;

    // Saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (reject_c && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_spike_rle_encoder.sv
// tb_spike_rle_encoder: scoreboard bench for spike_rle_encoder (GAP_W=7, DEPTH=4).
// Expected events are queued as stimulus is driven; a negedge monitor logs every
// handshake pop, and each test task compares the log against its expectations.
module tb_spike_rle_encoder;
    localparam int unsigned GAP_W = 7;
    localparam int unsigned DEPTH = 4;
`ifdef SPIKE_RLE_DROP_CNT_EN
    localparam logic [7:0] EXP_DROP = 8'd2;
`else
    localparam logic [7:0] EXP_DROP = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       spike;
    logic [2:0] fill;
    logic       ovf;
    logic [7:0] drop_cnt;

    spike_rle_encoder_if #(.GAP_W(GAP_W)) ev ();

    spike_rle_encoder #(.GAP_W(GAP_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .spike    (spike),
        .ev       (ev.master),
        .fill     (fill),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] got_mem [0:4095];
    int         got_wr = 0;
    int         got_rd = 0;

    // Log each accepted head; the pop happens at the following rising edge
    always @(negedge clk) begin
        if (rst === 1'b0 && ev.ev_valid === 1'b1 && ev.ev_ready === 1'b1) begin
            got_mem[got_wr % 4096] <= ev.ev_data;
            got_wr                 <= got_wr + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; en = 1'b0; spike = 1'b0; ev.ev_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        got_rd = got_wr;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; spike = 1'b1; ev.ev_ready = 1'b0;
        tick();
        tick();
        n_checks++; if (fill !== 3'd0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", fill); end
        n_checks++; if (ev.ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ev.ev_valid); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
        n_checks++; if (ev.ev_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", ev.ev_data); end
        rst = 1'b0; en = 1'b0; spike = 1'b0;
        tick();
        n_checks++; if (fill !== 3'd0) begin n_fail++; $display("FAIL reset_noqueue_fill: got %0d expected 0", fill); end
        n_checks++; if (ev.ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_noqueue_valid: got %b expected 0", ev.ev_valid); end
        got_rd = got_wr;
    endtask

    task automatic test_basic_gaps();
        logic [7:0] e;
        apply_reset();
        en = 1'b1; ev.ev_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            spike = (c == 0 || c == 3 || c == 4);
            if (c == 0) exp_q.push_back(8'h80);
            if (c == 3) exp_q.push_back(8'h82);
            if (c == 4) exp_q.push_back(8'h80);
            tick();
            if (spike) begin
                n_checks++;
                if (ev.ev_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_c%0d: got %b expected 1", c, ev.ev_valid); end
            end
        end
        en = 1'b0; spike = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        n_checks++;
        if (got_wr - got_rd != exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", got_wr - got_rd, exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_rd >= got_wr) begin n_fail++; $display("FAIL basic_event: got none expected %h", e); end
            else begin
                if (got_mem[got_rd % 4096] !== e) begin n_fail++; $display("FAIL basic_event: got %h expected %h", got_mem[got_rd % 4096], e); end
                got_rd++;
            end
        end
        got_rd = got_wr;
    endtask

    task automatic test_long_idle();
        logic [7:0] e;
        apply_reset();
        en = 1'b1; ev.ev_ready = 1'b1; spike = 1'b0;
        exp_q.push_back(8'h7F);
        exp_q.push_back(8'h7F);
        exp_q.push_back(8'hAC);
        for (int k = 0; k < 300; k++) tick();
        spike = 1'b1;
        tick();
        en = 1'b0; spike = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        n_checks++;
        if (got_wr - got_rd != exp_q.size()) begin n_fail++; $display("FAIL idle_count: got %0d expected %0d", got_wr - got_rd, exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_rd >= got_wr) begin n_fail++; $display("FAIL idle_event: got none expected %h", e); end
            else begin
                if (got_mem[got_rd % 4096] !== e) begin n_fail++; $display("FAIL idle_event: got %h expected %h", got_mem[got_rd % 4096], e); end
                got_rd++;
            end
        end
        got_rd = got_wr;
    endtask

    task automatic test_enable_gating();
        logic [7:0] e;
        apply_reset();
        ev.ev_ready = 1'b1; en = 1'b1; spike = 1'b1;
        exp_q.push_back(8'h80);
        tick();
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            spike = k[0];
            tick();
        end
        n_checks++; if (fill !== 3'd0) begin n_fail++; $display("FAIL gating_fill: got %0d expected 0", fill); end
        en = 1'b1; spike = 1'b0;
        tick();
        tick();
        spike = 1'b1;
        exp_q.push_back(8'h82);
        tick();
        en = 1'b0; spike = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        n_checks++;
        if (got_wr - got_rd != exp_q.size()) begin n_fail++; $display("FAIL gating_count: got %0d expected %0d", got_wr - got_rd, exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_rd >= got_wr) begin n_fail++; $display("FAIL gating_event: got none expected %h", e); end
            else begin
                if (got_mem[got_rd % 4096] !== e) begin n_fail++; $display("FAIL gating_event: got %h expected %h", got_mem[got_rd % 4096], e); end
                got_rd++;
            end
        end
        got_rd = got_wr;
    endtask

    task automatic test_overflow();
        logic [7:0] e;
        apply_reset();
        ev.ev_ready = 1'b0; en = 1'b1; spike = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) exp_q.push_back(8'h80);
            tick();
        end
        en = 1'b0; spike = 1'b0;
        n_checks++; if (fill !== 3'd4) begin n_fail++; $display("FAIL ovf_fill: got %0d expected 4", fill); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
        n_checks++; if (drop_cnt !== EXP_DROP) begin n_fail++; $display("FAIL ovf_drop: got %0d expected %0d", drop_cnt, EXP_DROP); end
        tick();
        n_checks++; if (ev.ev_data !== 8'h80 || ev.ev_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_head_stable: got %h/%b expected 80/1", ev.ev_data, ev.ev_valid); end
        ev.ev_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        n_checks++; if (fill !== 3'd0) begin n_fail++; $display("FAIL ovf_drained_fill: got %0d expected 0", fill); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
        n_checks++;
        if (got_wr - got_rd != exp_q.size()) begin n_fail++; $display("FAIL ovf_count: got %0d expected %0d", got_wr - got_rd, exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_rd >= got_wr) begin n_fail++; $display("FAIL ovf_event: got none expected %h", e); end
            else begin
                if (got_mem[got_rd % 4096] !== e) begin n_fail++; $display("FAIL ovf_event: got %h expected %h", got_mem[got_rd % 4096], e); end
                got_rd++;
            end
        end
        got_rd = got_wr;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] e;
        logic       pat [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] gap_ev;
        apply_reset();
        ev.ev_ready = 1'b0; en = 1'b1;
        gap_ev = 8'h80;
        for (int k = 0; k < 10; k++) begin
            spike = pat[k];
            if (pat[k]) begin exp_q.push_back(gap_ev); gap_ev = gap_ev + 8'd1; end
            tick();
        end
        n_checks++; if (fill !== 3'd4) begin n_fail++; $display("FAIL fullpp_prefill: got %0d expected 4", fill); end
        spike = 1'b0;
        tick();
        spike = 1'b1; ev.ev_ready = 1'b1;
        exp_q.push_back(8'h81);
        tick();
        n_checks++; if (fill !== 3'd4) begin n_fail++; $display("FAIL fullpp_fill: got %0d expected 4", fill); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL fullpp_ovf: got %b expected 0", ovf); end
        n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL fullpp_drop: got %0d expected 0", drop_cnt); end
        en = 1'b0; spike = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        n_checks++;
        if (got_wr - got_rd != exp_q.size()) begin n_fail++; $display("FAIL fullpp_count: got %0d expected %0d", got_wr - got_rd, exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_rd >= got_wr) begin n_fail++; $display("FAIL fullpp_event: got none expected %h", e); end
            else begin
                if (got_mem[got_rd % 4096] !== e) begin n_fail++; $display("FAIL fullpp_event: got %h expected %h", got_mem[got_rd % 4096], e); end
                got_rd++;
            end
        end
        got_rd = got_wr;
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        apply_reset();
        ev.ev_ready = 1'b0; en = 1'b1; spike = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        spike = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0;
        got_rd = got_wr;
        exp_q.delete();
        n_checks++; if (fill !== 3'd0) begin n_fail++; $display("FAIL midrst_fill: got %0d expected 0", fill); end
        n_checks++; if (ev.ev_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", ev.ev_valid); end
        en = 1'b1; spike = 1'b1; ev.ev_ready = 1'b1;
        exp_q.push_back(8'h80);
        tick();
        en = 1'b0; spike = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        n_checks++;
        if (got_wr - got_rd != exp_q.size()) begin n_fail++; $display("FAIL midrst_count: got %0d expected %0d", got_wr - got_rd, exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_rd >= got_wr) begin n_fail++; $display("FAIL midrst_event: got none expected %h", e); end
            else begin
                if (got_mem[got_rd % 4096] !== e) begin n_fail++; $display("FAIL midrst_event: got %h expected %h", got_mem[got_rd % 4096], e); end
                got_rd++;
            end
        end
        got_rd = got_wr;
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        logic [6:0] m_gap;
        apply_reset();
        ev.ev_ready = 1'b1; en = 1'b1; spike = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(8'h80);
            tick();
        end
        n_checks++; if (fill !== 3'd1) begin n_fail++; $display("FAIL b2b_fill: got %0d expected 1", fill); end
        // random enable/spike traffic checked against a reference gap encoder
        m_gap = 7'd0;
        for (int k = 0; k < 600; k++) begin
            en    = ($urandom_range(0, 7) != 0);
            spike = (k < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
            if (en) begin
                if (spike) begin exp_q.push_back({1'b1, m_gap}); m_gap = 7'd0; end
                else if (m_gap == 7'd127) begin exp_q.push_back(8'h7F); m_gap = 7'd0; end
                else m_gap = m_gap + 7'd1;
            end
            tick();
        end
        en = 1'b0; spike = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b expected 0", ovf); end
        n_checks++;
        if (got_wr - got_rd != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", got_wr - got_rd, exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_rd >= got_wr) begin n_fail++; $display("FAIL b2b_event: got none expected %h", e); end
            else begin
                if (got_mem[got_rd % 4096] !== e) begin n_fail++; $display("FAIL b2b_event: got %h expected %h", got_mem[got_rd % 4096], e); end
                got_rd++;
            end
        end
        got_rd = got_wr;
    endtask

    initial begin
        test_reset();
        test_basic_gaps();
        test_long_idle();
        test_enable_gating();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
